watch_core_param: RTL
=====================

// Module: watch_core_param
// PURPOSE
//  Parametrised next-gen timekeeping core: hundredths/sec/min/hour counters driven by an
//  internal prescaler, with an explicit RUN/SET FSM, per-field up/down adjust and 12/24h output.
//  Sits under the UART watch/stopwatch top. Takes single-cycle, already-debounced command
//  pulses and feeds the display mux/encoder.
// PARAMETERS
//  CLK_HZ     100_000_000  input clock frequency; CLK_HZ/TICK_HZ must be an integer >= 2
//  TICK_HZ    100          rate of msec increments; msec range is 0..TICK_HZ-1, TICK_HZ <= 128
//  HOUR_12    0            0: hour out 0..23; 1: hour out 1..12 with o_pm
//  INIT_HOUR  12           hour value after reset, 24h encoding, 0..23
// PORTS
//  clk         in   1  system clock
//  rst         in   1  asynchronous reset, active-high
//  i_mode      in   1  pulse: toggle RUN<->SET
//  i_sel       in   2  field select in SET: 0=sec 1=min 2=hour 3=none
//  i_up        in   1  pulse: increment selected field (SET only)
//  i_down      in   1  pulse: decrement selected field (SET only)
//  msec        out  7  hundredths, 0..TICK_HZ-1
//  sec         out  6  0..59
//  min         out  6  0..59
//  hour        out  5  0..23, or 1..12 if HOUR_12
//  o_pm        out  1  1 when internal hour >= 12; always 0 if HOUR_12=0
//  o_set_mode  out  1  1 while FSM is in SET
//  o_day_tick  out  1  1-cycle pulse on the 23:59:59.(TICK_HZ-1) -> 00:00:00.00 rollover
// BEHAVIOUR
//  Reset: state=RUN, prescaler=0, msec=0, sec=0, min=0, hour_int=INIT_HOUR,
//   o_day_tick=0, o_set_mode=0.
//  All counters and state are registered. hour/o_pm are combinational from hour_int
//   (12h map: 0->12 AM, 1..11 AM, 12->12 PM, 13..23 -> 1..11 PM).
//  Prescaler counts 0..CLK_HZ/TICK_HZ-1 in RUN only. tick=1 on the terminal count cycle.
//   Counters update on the clock edge ending that cycle (latency 1 from tick).
//  Carry chain, same edge: msec wraps -> sec+1; sec 59 wraps -> min+1; min 59 wraps -> hour+1;
//   hour 23 wraps -> 0 and o_day_tick=1 for exactly that cycle.
//  FSM RUN: i_mode -> SET. On entry to SET, prescaler and msec clear to 0 and time freezes.
//  FSM SET: i_mode -> RUN, with prescaler still 0, so the first tick comes a full period later.
//   i_up: selected field +1, wraps 59->0 (hour 23->0) with no carry into other fields.
//   i_down: selected field -1, wraps 0->59 (hour 0->23) with no borrow.
//   i_sel=3: adjust pulses are ignored.
//  Conflicts: i_up&i_down in the same cycle -> no change. i_mode in the same cycle as
//   i_up/i_down -> mode toggles and the adjust is dropped. i_up/i_down in RUN -> ignored.
//   i_sel changes take effect on the same cycle's adjust.
//  Adjusting never asserts o_day_tick.
//  rst asserted at any time, including mid-SET or on the rollover cycle, returns everything
//   to reset values immediately.
// STRUCTURE
//  watch_pkg: field widths (MSEC_W=7, SEC_W=6, MIN_W=6, HOUR_W=5), field maxima
//   (59, 23), FSM state encodings (ST_RUN, ST_SET), SEL_* constants.
//  Sub-module watch_field_cnt #(MAX, W): one mod-(MAX+1) counter with clr, inc, dec and
//   en_carry_in, giving a carry_out on wrap by inc. Instantiate 4x (msec uses MAX=TICK_HZ-1).
//  FSM, prescaler, adjust decode and 12h mapping live in the top.
// TESTING (sim with CLK_HZ=1000, TICK_HZ=100 -> tick every 10 clk)
//  Reset: rst=1 -> 00:00:00.00, hour_int=12; HOUR_12=1 gives hour=12, o_pm=1;
//   first msec=1 exactly 10 clk after release.
//  Rollover: set 23:59:59, run 100 ticks -> 00:00:00.00, o_day_tick high for 1 clk, o_pm=0.
//  Adjust wrap: SET, i_sel=1, min=59, i_up -> min=0, hour unchanged; i_sel=2, hour=0,
//   i_down -> 23.
//  Freeze and resume: RUN msec=57 -> i_mode -> msec=0 and held 50 clk; i_mode -> msec=1
//   exactly 10 clk later.
//  Conflicts: i_up&i_down together -> no change; i_mode+i_up together -> state toggles,
//   field unchanged; i_up in RUN -> ignored.
//  Async reset mid-SET: rst pulse during SET -> RUN, INIT_HOUR, o_set_mode=0 with no clk edge.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared widths, limits, FSM states and field selects for the watch core.
// Also holds the 24h -> 12h display mapping.
package watch_pkg;

    localparam int MSEC_W = 7;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_e;

    localparam logic [1:0] SEL_SEC  = 2'd0;
    localparam logic [1:0] SEL_MIN  = 2'd1;
    localparam logic [1:0] SEL_HOUR = 2'd2;
    localparam logic [1:0] SEL_NONE = 2'd3;

    // Returns {pm, hour12}: 0 -> 12 AM, 12 -> 12 PM, 13..23 -> 1..11 PM.
    function automatic logic [HOUR_W:0] map_12h(input logic [HOUR_W-1:0] h);
        logic [HOUR_W-1:0] h12;
        logic              pm;
        pm  = (h >= HOUR_W'(12));
        h12 = h;
        if (h == '0) begin
            h12 = HOUR_W'(12);
        end else if (h > HOUR_W'(12)) begin
            h12 = h - HOUR_W'(12);
        end
        return {pm, h12};
    endfunction

endpackage

// File: rtl/watch_field_cnt.sv
// One mod-(MAX+1) time field: chain increment with carry-out, plus
// carry-free up/down adjust and a synchronous clear.
module watch_field_cnt #(
    parameter int MAX     = 59,
    parameter int W       = 6,
    parameter int RST_VAL = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic         carry_in_i,
    output logic [W-1:0] cnt_o,
    output logic         carry_o
);

    localparam logic [W-1:0] MAXV = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;
    logic         at_max;

    assign at_max = (cnt_q == MAXV);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (carry_in_i) begin
            cnt_d = at_max ? '0 : cnt_q + W'(1);
        end else if (inc_i && !dec_i) begin
            cnt_d = at_max ? '0 : cnt_q + W'(1);
        end else if (dec_i && !inc_i) begin
            cnt_d = (cnt_q == '0) ? MAXV : cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= W'(RST_VAL);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Only the timekeeping chain carries; adjust wraps stay local.
    assign carry_o = carry_in_i & at_max & ~clr_i;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/watch_core_param.sv
// Timekeeping core: prescaler, RUN/SET FSM, field adjust decode,
// hundredths/sec/min/hour chain and optional 12h output.
module watch_core_param
    import watch_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 100,
    parameter int HOUR_12   = 0,
    parameter int INIT_HOUR = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_mode,
    input  logic [1:0]        i_sel,
    input  logic              i_up,
    input  logic              i_down,
    output logic [MSEC_W-1:0] msec,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic [HOUR_W-1:0] hour,
    output logic              o_pm,
    output logic              o_set_mode,
    output logic              o_day_tick
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

    state_e            state_q, state_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic              day_tick_q;

    logic              run;
    logic              enter_set;
    logic              tick;
    logic              adj_ok;
    logic              sec_adj, min_adj, hour_adj;
    logic              msec_co, sec_co, min_co, hour_co;
    logic [HOUR_W-1:0] hour_int;
    logic [HOUR_W:0]   h12;

    assign run       = (state_q == ST_RUN);
    assign enter_set = run & i_mode;
    assign tick      = run & (pre_q == PRE_MAX);

    always_comb begin
        state_d = state_q;
        if (i_mode) begin
            state_d = run ? ST_SET : ST_RUN;
        end
    end

    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        if (!run || enter_set || tick) begin
            pre_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pre_q      <= '0;
            day_tick_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            day_tick_q <= hour_co;
        end
    end

    // A mode pulse wins over any simultaneous adjust.
    assign adj_ok = ~run & ~i_mode & (i_up ^ i_down);

    always_comb begin
        sec_adj  = 1'b0;
        min_adj  = 1'b0;
        hour_adj = 1'b0;
        if (adj_ok) begin
            unique case (i_sel)
                SEL_SEC:  sec_adj  = 1'b1;
                SEL_MIN:  min_adj  = 1'b1;
                SEL_HOUR: hour_adj = 1'b1;
                default:  ;
            endcase
        end
    end

    watch_field_cnt #(
        .MAX     (TICK_HZ - 1),
        .W       (MSEC_W),
        .RST_VAL (0)
    ) u_msec (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (enter_set),
        .inc_i      (1'b0),
        .dec_i      (1'b0),
        .carry_in_i (tick),
        .cnt_o      (msec),
        .carry_o    (msec_co)
    );

    watch_field_cnt #(
        .MAX     (SEC_MAX),
        .W       (SEC_W),
        .RST_VAL (0)
    ) u_sec (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (1'b0),
        .inc_i      (sec_adj & i_up),
        .dec_i      (sec_adj & i_down),
        .carry_in_i (msec_co),
        .cnt_o      (sec),
        .carry_o    (sec_co)
    );

    watch_field_cnt #(
        .MAX     (MIN_MAX),
        .W       (MIN_W),
        .RST_VAL (0)
    ) u_min (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (1'b0),
        .inc_i      (min_adj & i_up),
        .dec_i      (min_adj & i_down),
        .carry_in_i (sec_co),
        .cnt_o      (min),
        .carry_o    (min_co)
    );

    watch_field_cnt #(
        .MAX     (HOUR_MAX),
        .W       (HOUR_W),
        .RST_VAL (INIT_HOUR)
    ) u_hour (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (1'b0),
        .inc_i      (hour_adj & i_up),
        .dec_i      (hour_adj & i_down),
        .carry_in_i (min_co),
        .cnt_o      (hour_int),
        .carry_o    (hour_co)
    );

    assign h12 = map_12h(hour_int);

    always_comb begin
        hour = hour_int;
        o_pm = 1'b0;
        if (HOUR_12 != 0) begin
            hour = h12[HOUR_W-1:0];
            o_pm = h12[HOUR_W];
        end
    end

    assign o_set_mode = ~run;
    assign o_day_tick = day_tick_q;

endmodule
